eval_arbiter: RTL and testbench

// - Shares the single evaluation-stack port between NREQ requesters (control FSM, LVA-move path, future invoke unit).
// - Each requester keeps its own pulse-trigger/done handshake; arbiter serialises ops onto evaltrigger/evaldone.
// - Sits between requesters and the eval stack.
// - Optional lock lets one requester hold the stack across multi-pop sequences (binary ALU ops, compares).

---
 rtl/bali_arb_pkg.sv | 13 +
 rtl/eval_arbiter_if.sv | 31 +++
 rtl/eval_arbiter_rr_picker.sv | 54 +++++
 rtl/eval_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_eval_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bali_arb_pkg.sv
// Shared definitions for the evaluation-stack arbiter: FSM state type and
// default sizing constants.
package bali_arb_pkg;

  localparam int ARB_NREQ   = 2;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1
  } arb_state_t;

endpackage

// File: rtl/eval_arbiter_if.sv
// Evaluation-stack port: the arbiter is the master that starts ops, the stack
// is the slave that reports completion and pop data.
interface eval_arbiter_if
  import bali_arb_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W
);

  logic              evaltrigger;
  logic              evalpush;
  logic [DATA_W-1:0] evalwrite;
  logic [DATA_W-1:0] evalread;
  logic              evaldone;

  modport master (
    output evaltrigger,
    output evalpush,
    output evalwrite,
    input  evalread,
    input  evaldone
  );

  modport slave (
    input  evaltrigger,
    input  evalpush,
    input  evalwrite,
    output evalread,
    output evaldone
  );

endinterface

// File: rtl/eval_arbiter_rr_picker.sv
// Combinational one-hot picker. Default build: round robin starting just after
// ptr and wrapping. With EVAL_ARB_FIXED_PRIO_EN defined: lowest index wins and
// ptr is ignored.
module rr_picker
  import bali_arb_pkg::*;
#(
  parameter int NREQ  = ARB_NREQ,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  cand,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  int sel_s;

  // Scan candidates from lowest to highest priority so the last hit wins.
  always_comb begin
    sel_s   = 0;
    gnt_vld = 1'b0;
`ifdef EVAL_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[k]) begin
        sel_s   = k;
        gnt_vld = 1'b1;
      end else begin
        sel_s   = sel_s;
        gnt_vld = gnt_vld;
      end
    end
`else
    // k = NREQ is ptr itself (lowest priority); k = 1 is ptr+1 (highest).
    for (int k = NREQ; k >= 1; k--) begin
      if (cand[(int'(ptr) + k) % NREQ]) begin
        sel_s   = (int'(ptr) + k) % NREQ;
        gnt_vld = 1'b1;
      end else begin
        sel_s   = sel_s;
        gnt_vld = gnt_vld;
      end
    end
`endif
    gnt_idx = IDX_W'(sel_s);
    gnt_oh  = {NREQ{1'b0}};
    if (gnt_vld) begin
      gnt_oh[sel_s] = 1'b1;
    end else begin
      gnt_oh = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/eval_arbiter.sv
// Serialises stack ops from NREQ requesters onto the single evaluation-stack
// port. Each requester has a capture slot; a two-state FSM issues one op at a
// time and returns completion as a per-requester done pulse. An owner may hold
// the stack between ops with req_lock. Define EVAL_ARB_FIXED_PRIO_EN for fixed
// priority (lowest index wins) instead of round robin.
module eval_arbiter
  import bali_arb_pkg::*;
#(
  parameter int NREQ   = ARB_NREQ,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_trigger,
  input  logic [NREQ-1:0]        req_push,
  input  logic [NREQ*DATA_W-1:0] req_write,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_done,
  output logic [DATA_W-1:0]      req_read,
  output logic                   proto_err,
  eval_arbiter_if.master         stk
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_t        state_r;
  logic [NREQ-1:0]   pending_r;
  logic [NREQ-1:0]   slot_push_r;
  logic [DATA_W-1:0] slot_write_r [NREQ];
  logic [IDX_W-1:0]  grant_r;
  logic [IDX_W-1:0]  owner_r;
  logic              locked_r;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [NREQ-1:0]   req_done_r;
  logic [DATA_W-1:0] req_read_r;
  logic              proto_err_r;
  logic              evaltrigger_r;
  logic              evalpush_r;
  logic [DATA_W-1:0] evalwrite_r;

  logic              done_now_s;
  logic [NREQ-1:0]   trig_ok_s;
  logic [NREQ-1:0]   trig_err_s;
  logic [NREQ-1:0]   cand_s;
  logic [NREQ-1:0]   owner_oh_s;
  logic              lock_hold_s;
  logic [NREQ-1:0]   elig_s;
  logic [NREQ-1:0]   pick_oh_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_vld_s;
  logic              pick_push_s;
  logic [DATA_W-1:0] pick_write_s;

  // Classify triggers: a requester whose op is completing this cycle may
  // queue a fresh op; any other trigger while pending is a protocol error.
  always_comb begin
    done_now_s = (state_r == ARB_WAIT) && stk.evaldone;
    trig_ok_s  = {NREQ{1'b0}};
    trig_err_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (req_trigger[i]) begin
        if (pending_r[i] && !(done_now_s && (grant_r == IDX_W'(i)))) begin
          trig_err_s[i] = 1'b1;
        end else begin
          trig_ok_s[i] = 1'b1;
        end
      end else begin
        trig_ok_s[i]  = 1'b0;
        trig_err_s[i] = 1'b0;
      end
    end
  end

  // Eligibility: same-cycle triggers count; a held lock masks out everyone
  // but the owner (possibly leaving the stack idle).
  always_comb begin
    cand_s      = pending_r | trig_ok_s;
    owner_oh_s  = {NREQ{1'b0}};
    owner_oh_s[owner_r] = 1'b1;
    lock_hold_s = locked_r & req_lock[owner_r];
    if (lock_hold_s) begin
      elig_s = cand_s & owner_oh_s;
    end else begin
      elig_s = cand_s;
    end
  end

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .cand    (elig_s),
    .ptr     (rr_ptr_r),
    .gnt_oh  (pick_oh_s),
    .gnt_idx (pick_idx_s),
    .gnt_vld (pick_vld_s)
  );

  // Operand for the picked requester: live inputs if it triggered this cycle.
  always_comb begin
    if (|(trig_ok_s & pick_oh_s)) begin
      pick_push_s  = req_push[pick_idx_s];
      pick_write_s = req_write[int'(pick_idx_s) * DATA_W +: DATA_W];
    end else begin
      pick_push_s  = slot_push_r[pick_idx_s];
      pick_write_s = slot_write_r[pick_idx_s];
    end
  end

  // Arbiter FSM, capture slots and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ARB_IDLE;
      pending_r     <= {NREQ{1'b0}};
      slot_push_r   <= {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
        slot_write_r[i] <= {DATA_W{1'b0}};
      end
      grant_r       <= {IDX_W{1'b0}};
      owner_r       <= {IDX_W{1'b0}};
      locked_r      <= 1'b0;
      rr_ptr_r      <= IDX_W'(NREQ - 1);
      req_done_r    <= {NREQ{1'b0}};
      req_read_r    <= {DATA_W{1'b0}};
      proto_err_r   <= 1'b0;
      evaltrigger_r <= 1'b0;
      evalpush_r    <= 1'b0;
      evalwrite_r   <= {DATA_W{1'b0}};
    end else begin
      req_done_r  <= {NREQ{1'b0}};
      proto_err_r <= |trig_err_s;
      case (state_r)
        ARB_IDLE: begin
          locked_r <= lock_hold_s;
          if (pick_vld_s) begin
            grant_r       <= pick_idx_s;
            rr_ptr_r      <= pick_idx_s;
            evaltrigger_r <= 1'b1;
            evalpush_r    <= pick_push_s;
            evalwrite_r   <= pick_write_s;
            state_r       <= ARB_WAIT;
          end else begin
            evaltrigger_r <= 1'b0;
          end
        end
        ARB_WAIT: begin
          evaltrigger_r <= 1'b0;
          if (stk.evaldone) begin
            if (!evalpush_r) begin
              req_read_r <= stk.evalread;
            end
            req_done_r[grant_r] <= 1'b1;
            pending_r[grant_r]  <= 1'b0;
            owner_r             <= grant_r;
            locked_r            <= req_lock[grant_r];
            state_r             <= ARB_IDLE;
          end
        end
        default: begin
          state_r       <= ARB_IDLE;
          evaltrigger_r <= 1'b0;
        end
      endcase
      // Capture last so a fresh op from the completing requester survives.
      for (int i = 0; i < NREQ; i++) begin
        if (trig_ok_s[i]) begin
          pending_r[i]    <= 1'b1;
          slot_push_r[i]  <= req_push[i];
          slot_write_r[i] <= req_write[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign req_done        = req_done_r;
  assign req_read        = req_read_r;
  assign proto_err       = proto_err_r;
  assign stk.evaltrigger = evaltrigger_r;
  assign stk.evalpush    = evalpush_r;
  assign stk.evalwrite   = evalwrite_r;

endmodule

// File: tb/tb_eval_arbiter.sv
// Self-checking bench for eval_arbiter: behavioural LIFO stack responder with
// random latency, an event monitor, and directed plus randomized scenarios.
module tb_eval_arbiter;
  import bali_arb_pkg::*;

  localparam int NREQ   = 2;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]        req_trigger;
  logic [NREQ-1:0]        req_push;
  logic [NREQ*DATA_W-1:0] req_write;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ-1:0]        req_done;
  logic [DATA_W-1:0]      req_read;
  logic                   proto_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eval_arbiter_if #(.DATA_W(DATA_W)) stk ();

  eval_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_trigger (req_trigger),
    .req_push    (req_push),
    .req_write   (req_write),
    .req_lock    (req_lock),
    .req_done    (req_done),
    .req_read    (req_read),
    .proto_err   (proto_err),
    .stk         (stk)
  );

  // ---------------- stack responder (LIFO, random latency) ----------------
  logic [31:0] stack_q [$];
  int          rsp_busy = 0;
  int          rsp_cnt  = 0;
  logic [31:0] rsp_val;
  int          lat_min  = 1;
  int          lat_max  = 3;
  bit          spurious_req = 1'b0;

  initial begin
    stk.evaldone = 1'b0;
    stk.evalread = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stk.evaldone = 1'b0;
        rsp_busy     = 0;
        stack_q.delete();
      end else begin
        stk.evaldone = 1'b0;
        if (spurious_req) begin
          stk.evaldone = 1'b1;
          stk.evalread = 32'h5A5A_5A5A;
          spurious_req = 1'b0;
        end
        if (rsp_busy != 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            stk.evaldone = 1'b1;
            stk.evalread = rsp_val;
            rsp_busy     = 0;
          end
        end
        if (stk.evaltrigger) begin
          if (stk.evalpush) begin
            stack_q.push_back(stk.evalwrite);
            rsp_val = $urandom;
          end else if (stack_q.size() > 0) begin
            rsp_val = stack_q.pop_back();
          end else begin
            rsp_val = 32'hBAD0_0000;
          end
          rsp_busy = 1;
          rsp_cnt  = $urandom_range(lat_max, lat_min);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] tr_data_q [$];
  bit          tr_push_q [$];
  int          dn_idx_q  [$];
  logic [31:0] dn_read_q [$];
  int          dn_cnt    [NREQ];
  int          perr_cnt  = 0;
  bit          prev_trig = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_trig = 1'b0;
      end else begin
        if (stk.evaltrigger) begin
          n_chk++;
          if (prev_trig) begin
            n_fail++;
            $display("FAIL trig_pulse_width: evaltrigger high 2 cycles, required 1");
          end
          tr_data_q.push_back(stk.evalwrite);
          tr_push_q.push_back(stk.evalpush);
        end
        prev_trig = stk.evaltrigger;
        if (req_done != 2'b00) begin
          n_chk++;
          if ($countones(req_done) != 1) begin
            n_fail++;
            $display("FAIL done_onehot: req_done=%b, required one-hot", req_done);
          end
          for (int i = 0; i < NREQ; i++) begin
            if (req_done[i]) begin
              dn_idx_q.push_back(i);
              dn_cnt[i]++;
            end
          end
          dn_read_q.push_back(req_read);
        end
        if (proto_err) perr_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    tr_data_q.delete();
    tr_push_q.delete();
    dn_idx_q.delete();
    dn_read_q.delete();
    for (int i = 0; i < NREQ; i++) dn_cnt[i] = 0;
    perr_cnt = 0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_trigger = 2'b00;
    req_push    = 2'b00;
    req_write   = 64'h0;
    req_lock    = 2'b00;
    repeat (3) step();
    rst = 1'b0;
    step();
    clear_logs();
  endtask

  task automatic fire(input logic [1:0] mask, input logic [1:0] push,
                      input logic [31:0] d0, input logic [31:0] d1);
    req_trigger = mask;
    req_push    = push;
    req_write   = {d1, d0};
    step();
    req_trigger = 2'b00;
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    for (int c = 0; c < budget; c++) begin
      if (dn_idx_q.size() >= n) break;
      step();
    end
    n_chk++;
    if (dn_idx_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d completions, required %0d", name, dn_idx_q.size(), n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_chk += 6;
    if (req_done !== 2'b00) begin n_fail++; $display("FAIL rst_req_done: %b, required 00", req_done); end
    if (req_read !== 32'h0) begin n_fail++; $display("FAIL rst_req_read: %h, required 0", req_read); end
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_proto_err: %b, required 0", proto_err); end
    if (stk.evaltrigger !== 1'b0) begin n_fail++; $display("FAIL rst_evaltrigger: %b, required 0", stk.evaltrigger); end
    if (stk.evalpush !== 1'b0) begin n_fail++; $display("FAIL rst_evalpush: %b, required 0", stk.evalpush); end
    if (stk.evalwrite !== 32'h0) begin n_fail++; $display("FAIL rst_evalwrite: %h, required 0", stk.evalwrite); end
    // spurious evaldone in IDLE must not complete anything
    spurious_req = 1'b1;
    repeat (4) step();
    n_chk += 2;
    if (dn_idx_q.size() != 0) begin n_fail++; $display("FAIL spurious_done: %0d completions, required 0", dn_idx_q.size()); end
    if (tr_data_q.size() != 0) begin n_fail++; $display("FAIL spurious_trig: %0d triggers, required 0", tr_data_q.size()); end
  endtask

  task automatic test_push();
    do_reset();
    fire(2'b01, 2'b01, 32'h0000_002A, 32'h0);
    n_chk += 3;
    if (stk.evaltrigger !== 1'b1) begin n_fail++; $display("FAIL push_trig: %b, required 1", stk.evaltrigger); end
    if (stk.evalpush !== 1'b1) begin n_fail++; $display("FAIL push_evalpush: %b, required 1", stk.evalpush); end
    if (stk.evalwrite !== 32'h0000_002A) begin n_fail++; $display("FAIL push_evalwrite: %h, required 2a", stk.evalwrite); end
    step();
    n_chk++;
    if (stk.evaltrigger !== 1'b0) begin n_fail++; $display("FAIL push_trig_pulse: %b, required 0", stk.evaltrigger); end
    wait_done(1, 20, "push");
    n_chk += 2;
    if (req_done !== 2'b01) begin n_fail++; $display("FAIL push_done: %b, required 01", req_done); end
    if (req_read !== 32'h0) begin n_fail++; $display("FAIL push_read_held: %h, required 0", req_read); end
    step();
    n_chk++;
    if (req_done !== 2'b00) begin n_fail++; $display("FAIL push_done_pulse: %b, required 00", req_done); end
  endtask

  task automatic test_pop();
    do_reset();
    stack_q.push_back(32'hDEAD_BEEF);
    fire(2'b10, 2'b00, 32'h0, 32'h1111_1111);
    wait_done(1, 20, "pop");
    n_chk += 2;
    if (req_done !== 2'b10) begin n_fail++; $display("FAIL pop_done: %b, required 10", req_done); end
    if (req_read !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pop_read: %h, required deadbeef", req_read); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      fire(2'b11, 2'b11, 32'hA000_0000 + 32'(r), 32'hB000_0000 + 32'(r));
      wait_done(2 * (r + 1), 50, "rr");
    end
    n_chk += 3;
    if (tr_data_q.size() != 8) begin n_fail++; $display("FAIL rr_count: %0d ops, required 8", tr_data_q.size()); end
    if (perr_cnt != 0) begin n_fail++; $display("FAIL rr_proto_err: %0d, required 0", perr_cnt); end
    if (dn_cnt[0] != 4 || dn_cnt[1] != 4) begin n_fail++; $display("FAIL rr_balance: %0d/%0d, required 4/4", dn_cnt[0], dn_cnt[1]); end
    for (int k = 0; k < 8 && k < tr_data_q.size() && k < dn_idx_q.size(); k++) begin
      exp_d = ((k % 2) == 0) ? 32'hA000_0000 + 32'(k / 2) : 32'hB000_0000 + 32'(k / 2);
      n_chk += 2;
      if (tr_data_q[k] !== exp_d) begin n_fail++; $display("FAIL rr_order_%0d: write %h, required %h", k, tr_data_q[k], exp_d); end
      if (dn_idx_q[k] != (k % 2)) begin n_fail++; $display("FAIL rr_done_%0d: req %0d, required %0d", k, dn_idx_q[k], k % 2); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    lat_min = 3; lat_max = 3;
    stack_q.push_back(32'h0000_0111);
    stack_q.push_back(32'h0000_0222);
    stack_q.push_back(32'h0000_0333);
    req_lock = 2'b01;
    fire(2'b01, 2'b00, 32'hA000_0000, 32'h0);
    fire(2'b10, 2'b00, 32'h0, 32'hB000_0000);
    wait_done(1, 30, "lock1");
    repeat (5) step();
    n_chk++;
    if (tr_data_q.size() != 1) begin n_fail++; $display("FAIL lock_hold: %0d ops issued, required 1", tr_data_q.size()); end
    fire(2'b01, 2'b00, 32'hA000_0001, 32'h0);
    wait_done(2, 30, "lock2");
    req_lock = 2'b00;
    wait_done(3, 30, "lock3");
    n_chk++;
    if (dn_idx_q.size() >= 3) begin
      n_chk += 6;
      if (dn_idx_q[0] != 0 || dn_idx_q[1] != 0 || dn_idx_q[2] != 1) begin
        n_fail++; $display("FAIL lock_order: %0d,%0d,%0d, required 0,0,1", dn_idx_q[0], dn_idx_q[1], dn_idx_q[2]);
      end
      if (tr_data_q[2] !== 32'hB000_0000) begin n_fail++; $display("FAIL lock_third_op: %h, required b0000000", tr_data_q[2]); end
      if (dn_read_q[0] !== 32'h333) begin n_fail++; $display("FAIL lock_read0: %h, required 333", dn_read_q[0]); end
      if (dn_read_q[1] !== 32'h222) begin n_fail++; $display("FAIL lock_read1: %h, required 222", dn_read_q[1]); end
      if (dn_read_q[2] !== 32'h111) begin n_fail++; $display("FAIL lock_read2: %h, required 111", dn_read_q[2]); end
      if (perr_cnt != 0) begin n_fail++; $display("FAIL lock_proto_err: %0d, required 0", perr_cnt); end
    end else begin
      n_fail++; $display("FAIL lock_completions: %0d, required 3", dn_idx_q.size());
    end
    lat_min = 1; lat_max = 3;
  endtask

  task automatic test_proto_err_and_reset();
    do_reset();
    lat_min = 4; lat_max = 4;
    fire(2'b01, 2'b01, 32'hC000_0000, 32'h0);
    fire(2'b10, 2'b01, 32'h0, 32'hD000_0000);
    fire(2'b10, 2'b01, 32'h0, 32'hD000_0001);
    wait_done(2, 50, "perr");
    repeat (10) step();
    n_chk += 4;
    if (perr_cnt != 1) begin n_fail++; $display("FAIL perr_count: %0d pulses, required 1", perr_cnt); end
    if (tr_data_q.size() != 2) begin n_fail++; $display("FAIL perr_ops: %0d ops, required 2", tr_data_q.size()); end
    if (dn_cnt[1] != 1) begin n_fail++; $display("FAIL perr_req1_done: %0d, required 1", dn_cnt[1]); end
    if (tr_data_q.size() >= 2 && tr_data_q[1] !== 32'hD000_0000) begin
      n_fail++; $display("FAIL perr_kept_first: %h, required d0000000", tr_data_q[1]);
    end
    // reset while the stack op is in flight
    clear_logs();
    fire(2'b01, 2'b01, 32'hE000_0000, 32'h0);
    step();
    rst = 1'b1;
    step();
    n_chk += 4;
    if (req_done !== 2'b00) begin n_fail++; $display("FAIL midrst_done: %b, required 00", req_done); end
    if (stk.evaltrigger !== 1'b0) begin n_fail++; $display("FAIL midrst_trig: %b, required 0", stk.evaltrigger); end
    if (stk.evalwrite !== 32'h0) begin n_fail++; $display("FAIL midrst_write: %h, required 0", stk.evalwrite); end
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL midrst_perr: %b, required 0", proto_err); end
    rst = 1'b0;
    lat_min = 1; lat_max = 3;
    repeat (6) step();
    n_chk++;
    if (dn_idx_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_done: %0d completions, required 0", dn_idx_q.size()); end
    fire(2'b01, 2'b01, 32'hE000_0001, 32'h0);
    wait_done(1, 20, "postrst");
    n_chk++;
    if (req_done !== 2'b01) begin n_fail++; $display("FAIL postrst_done: %b, required 01", req_done); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    do_reset();
    lat_min = 2; lat_max = 2;
    fire(2'b01, 2'b01, 32'hF000_0000, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (stk.evaldone) seen = 1'b1;
      else step();
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL b2b_evaldone_timeout: not seen, required within 20 cycles"); end
    fire(2'b01, 2'b01, 32'hF000_0001, 32'h0);
    wait_done(2, 30, "b2b");
    n_chk += 3;
    if (perr_cnt != 0) begin n_fail++; $display("FAIL b2b_proto_err: %0d, required 0", perr_cnt); end
    if (dn_cnt[0] != 2) begin n_fail++; $display("FAIL b2b_done: %0d, required 2", dn_cnt[0]); end
    if (tr_data_q.size() < 2 || tr_data_q[tr_data_q.size()-1] !== 32'hF000_0001) begin
      n_fail++; $display("FAIL b2b_second_op: %0d ops, required second write f0000001", tr_data_q.size());
    end
    lat_min = 1; lat_max = 3;
  endtask

  task automatic test_random();
    int          issued [NREQ];
    logic [31:0] exp_d  [NREQ][$];
    bit          exp_p  [NREQ][$];
    logic [31:0] model  [$];
    logic [31:0] d, e;
    bit          p;
    int          id;
    do_reset();
    for (int i = 0; i < NREQ; i++) issued[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      if (issued[0] >= 30 && issued[1] >= 30 && dn_cnt[0] >= 30 && dn_cnt[1] >= 30) break;
      req_trigger = 2'b00;
      for (int i = 0; i < NREQ; i++) begin
        if (issued[i] < 30 && issued[i] == dn_cnt[i] && $urandom_range(2, 0) == 0) begin
          d = {4'(i + 1), 28'($urandom)};
          p = 1'($urandom_range(1, 0));
          req_trigger[i] = 1'b1;
          req_push[i]    = p;
          req_write[i*DATA_W +: DATA_W] = d;
          exp_d[i].push_back(d);
          exp_p[i].push_back(p);
          issued[i]++;
        end
      end
      step();
    end
    req_trigger = 2'b00;
    step();
    n_chk += 3;
    if (dn_cnt[0] != 30 || dn_cnt[1] != 30) begin n_fail++; $display("FAIL rnd_done_count: %0d/%0d, required 30/30", dn_cnt[0], dn_cnt[1]); end
    if (perr_cnt != 0) begin n_fail++; $display("FAIL rnd_proto_err: %0d, required 0", perr_cnt); end
    if (tr_data_q.size() != 60 || dn_idx_q.size() != 60) begin
      n_fail++; $display("FAIL rnd_op_count: %0d ops %0d dones, required 60", tr_data_q.size(), dn_idx_q.size());
    end
    for (int k = 0; k < tr_data_q.size() && k < dn_idx_q.size(); k++) begin
      id = int'(tr_data_q[k][31:28]) - 1;
      n_chk++;
      if (id < 0 || id >= NREQ || exp_d[id].size() == 0) begin
        n_fail++; $display("FAIL rnd_unknown_op_%0d: write %h, required an outstanding op", k, tr_data_q[k]);
      end else begin
        d = exp_d[id].pop_front();
        p = exp_p[id].pop_front();
        n_chk += 2;
        if (tr_data_q[k] !== d || tr_push_q[k] !== p) begin
          n_fail++; $display("FAIL rnd_op_%0d: write %h push %b, required %h %b", k, tr_data_q[k], tr_push_q[k], d, p);
        end
        if (dn_idx_q[k] != id) begin n_fail++; $display("FAIL rnd_done_req_%0d: %0d, required %0d", k, dn_idx_q[k], id); end
        if (p) begin
          model.push_back(d);
        end else begin
          e = (model.size() > 0) ? model.pop_back() : 32'hBAD0_0000;
          n_chk++;
          if (dn_read_q[k] !== e) begin n_fail++; $display("FAIL rnd_read_%0d: %h, required %h", k, dn_read_q[k], e); end
        end
      end
    end
  endtask

`ifdef EVAL_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    req_trigger = 2'b11;
    req_push    = 2'b11;
    req_write   = {32'hB000_0000, 32'hA000_0000};
    step();
    req_trigger = 2'b00;
    for (int c = 0; c < 400 && dn_idx_q.size() < 8; c++) begin
      req_trigger = req_done;
      step();
    end
    req_trigger = 2'b00;
    n_chk++;
    if (dn_idx_q.size() < 8) begin n_fail++; $display("FAIL fp_count: %0d, required 8", dn_idx_q.size()); end
    for (int k = 0; k < 8 && k < dn_idx_q.size(); k++) begin
      n_chk++;
      if (dn_idx_q[k] != 0) begin n_fail++; $display("FAIL fp_grant_%0d: req %0d, required 0", k, dn_idx_q[k]); end
    end
  endtask
`endif

  initial begin
    rst         = 1'b1;
    req_trigger = 2'b00;
    req_push    = 2'b00;
    req_write   = 64'h0;
    req_lock    = 2'b00;
    for (int i = 0; i < NREQ; i++) dn_cnt[i] = 0;
    test_reset();
    test_push();
    test_pop();
`ifdef EVAL_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_lock();
    test_proto_err_and_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
